// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the streaming 1-to-2 demultiplexer.
//   WIDTH_DEFAULT : default data word width
//   slot_state_t  : EMPTY/FULL state of one output holding register
//   SEL_OUT0/1    : in_sel encodings for the two destinations
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// -----------------------------------------------------------------------------
// demux_out_slot
// One output of the demultiplexer: a single-entry holding register with an
// EMPTY/FULL state machine and a valid/ready output handshake.
// Optional feature macro: DEMUX_COUNT_EN adds a wrapping delivery counter.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   load      : write load_data into the slot on this edge
//   load_data : word to store
//   valid     : slot holds a word
//   ready     : consumer takes the word
//   data      : stored word
//   count     : words delivered (DEMUX_COUNT_EN only)
// -----------------------------------------------------------------------------
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
`ifdef DEMUX_COUNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_data;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a load wins over a drain on the same edge, so a slot that is
  // drained and reloaded together stays FULL and sustains one word per cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = SLOT_FULL;
    end else if ((r_state == SLOT_FULL) && ready) begin
      w_state_nxt = SLOT_EMPTY;
    end
  end

  // Output decode
  always_comb begin
    valid = (r_state == SLOT_FULL);
  end

  // Holding register: only a load changes it; a drain leaves the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= load_data;
    end
  end

  assign data = r_data;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Counts completed handshakes; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (valid && ready) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
`endif

endmodule

// File: rtl/demux_1x2_stream.sv
// -----------------------------------------------------------------------------
// demux_1x2_stream
// Streaming 1-to-2 demultiplexer. Each accepted input word is steered to
// output 0 or output 1 by in_sel; each output has its own one-entry slot so
// a stalled consumer only blocks words addressed to it.
// Optional feature macro: DEMUX_COUNT_EN adds per-output delivery counters.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   in_valid/in_ready/in_sel/in_data : input channel
//   out0_valid/out0_ready/out0_data  : output 0 channel
//   out1_valid/out1_ready/out1_data  : output 1 channel
//   out0_count/out1_count            : delivery counters (DEMUX_COUNT_EN only)
// -----------------------------------------------------------------------------
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
`endif
);

  logic w_rdy0;
  logic w_rdy1;
  logic w_load0;
  logic w_load1;

  // A slot can take a word if it is empty or is being drained this cycle.
  // in_ready looks only at the selected slot and never at in_valid.
  assign w_rdy0   = !out0_valid || out0_ready;
  assign w_rdy1   = !out1_valid || out1_ready;
  assign in_ready = (in_sel == SEL_OUT1) ? w_rdy1 : w_rdy0;

  assign w_load0  = in_valid && in_ready && (in_sel == SEL_OUT0);
  assign w_load1  = in_valid && in_ready && (in_sel == SEL_OUT1);

  demux_out_slot #(
    .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load0),
    .load_data (in_data),
    .valid     (out0_valid),
    .ready     (out0_ready),
    .data      (out0_data)
`ifdef DEMUX_COUNT_EN
    ,
    .count     (out0_count)
`endif
  );

  demux_out_slot #(
    .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load1),
    .load_data (in_data),
    .valid     (out1_valid),
    .ready     (out1_ready),
    .data      (out1_data)
`ifdef DEMUX_COUNT_EN
    ,
    .count     (out1_count)
`endif
  );

endmodule

// File: doc/demux_1x2_stream.md
Name: demux_1x2_stream

Overview:
- Streaming 1-to-2 demultiplexer; the routing counterpart of mux_2x1 in the datapath.
- Accepts one WIDTH-bit word per cycle on a valid/ready input channel.
- Steers each accepted word to output 0 or output 1 according to a select bit sampled with the data.
- Each output has a one-entry holding register with its own valid/ready handshake, so one stalled consumer does not block traffic to the other.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of per-output transfer counters (used only with DEMUX_COUNT_EN).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  source has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- in_sel  input  1  destination: 0 = output 0, 1 = output 1; sampled with in_data.
- in_data  input  WIDTH  input word.
- out0_valid  output  1  out0_data holds a word.
- out0_ready  input  1  consumer 0 takes the word.
- out0_data  output  WIDTH  output 0 word.
- out1_valid  output  1  out1_data holds a word.
- out1_ready  input  1  consumer 1 takes the word.
- out1_data  output  WIDTH  output 1 word.
- out0_count  output  CNT_W  words delivered on output 0 (DEMUX_COUNT_EN only).
- out1_count  output  CNT_W  words delivered on output 1 (DEMUX_COUNT_EN only).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, counters=0.
- Reset mid-operation drops buffered words immediately, without waiting for a clock edge.
- Per-output state machine: EMPTY / FULL. Reset state is EMPTY. outK_valid = (state == FULL).
- Ready rule (combinational):
  - in_ready = !outS_valid || outS_ready, where S = in_sel.
  - in_ready does not depend on in_valid.
- Accept rule: a transfer happens when in_valid && in_ready at a rising edge.
  - On that edge, outS_data <= in_data and outS state <= FULL.
  - Latency is 1 cycle from input acceptance to outS_valid=1.
- Drain rule: when outK_valid && outK_ready and no load to K occurs on the same edge, state <= EMPTY.
  - outK_data keeps its last value; it is not cleared.
- Simultaneous drain and load on the same output: state stays FULL and data is replaced by the new word. This gives full throughput of 1 word per cycle per output.
- The unselected output is never modified by an input transfer.
  - A load to one output may occur while the other is FULL and stalled.
- Stability rule: while outK_valid && !outK_ready, outK_data is stable.
- Source obligation: in_data and in_sel are held stable while in_valid && !in_ready.
- in_valid=0 means no state change other than drains.
- No data word is ever dropped or duplicated.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- With the macro defined:
  - outK_count increments by 1 on each edge where outK_valid && outK_ready.
  - Counters wrap from 2^CNT_W-1 to 0 and reset to 0.
- Without the macro: out0_count and out1_count are absent from the port list, and no counter logic is generated.

Decomposition:
- Package demux_pkg holds:
  - WIDTH_DEFAULT = 32.
  - Slot state enum {SLOT_EMPTY, SLOT_FULL}.
  - Constants SEL_OUT0 = 1'b0 and SEL_OUT1 = 1'b1.
- Sub-module demux_out_slot: one holding register plus EMPTY/FULL state machine and optional counter.
  - Ports: clk, reset, load, load_data, valid, ready, data.
  - Instanced twice.
- The top level contains only the select decode and the in_ready mux.

Test Plan:
- Reset and idle: assert reset mid-run with out0 FULL -> out0_valid and out1_valid drop to 0 immediately, data reads 0, in_ready=1.
- Basic route:
  - in_sel=0, in_data=32'h00000000, 1 cycle -> out0_valid=1 and out0_data=32'h00000000 next cycle; out1_valid stays 0.
  - in_sel=1, in_data=32'hFFFFFFFF -> out1_data=32'hFFFFFFFF one cycle after acceptance.
- Backpressure: out0_ready=0, send 32'hA5A5A5A5 then 32'h5A5A5A5A to sel 0 -> in_ready=0 on the second word and out0_data holds A5A5A5A5. Raise out0_ready -> second word loads on the next edge.
- Independence: out0 full and stalled; send 32'h12345678 to sel 1 -> accepted at once and out1_data=32'h12345678 while out0 is unchanged.
- Throughput: both readys=1; stream 8 words alternating sel -> in_ready=1 every cycle and every word appears once, in order, on its output. With DEMUX_COUNT_EN, out0_count=4 and out1_count=4.
- Counter wrap (DEMUX_COUNT_EN, CNT_W=4): 17 deliveries on out1 -> out1_count=1.
